// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler feeding one shared SIZE x SIZE unsigned multiplier.
// Up to NREQ requesters present operand pairs. A rotating-priority arbiter
// accepts at most one pair per cycle. The registered product is returned on a
// single valid/ready result channel, tagged with the index of the requester
// that issued it.
module mult_rr_scheduler #(
  parameter int unsigned SIZE = 8,
  parameter int unsigned NREQ = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*SIZE-1:0]      a_bus,
  input  logic [NREQ*SIZE-1:0]      b_bus,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [2*SIZE-1:0]         res_data,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic [CNTW-1:0]           issue_cnt
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned PW  = 2 * SIZE;
  // NREQ at the width of an un-wrapped index sum, so the compare stays width-matched.
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  // Result register, rotating priority pointer and issued-operation counter.
  logic              r_res_valid;
  logic [PW-1:0]     r_res_data;
  logic [IDW-1:0]    r_res_id;
  logic [IDW-1:0]    r_rr_ptr;
  logic [CNTW-1:0]   r_issue_cnt;

  logic              w_slot_free;
  logic              w_found;
  logic [IDW-1:0]    w_win;
  logic [IDW-1:0]    w_cand;
  logic              w_accept;
  logic [NREQ-1:0]   w_grant;
  logic [SIZE-1:0]   w_a;
  logic [SIZE-1:0]   w_b;
  logic [PW-1:0]     w_prod;
  logic [IDW-1:0]    w_next_ptr;

  // Fold an index sum in [0, 2*NREQ-2] back into [0, NREQ-1].
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW:0] sum);
    logic [IDW:0] adj;
    adj = (sum >= NREQ_W) ? (sum - NREQ_W) : sum;
    return adj[IDW-1:0];
  endfunction

  // The result register can take a new product when it is empty or being drained.
  assign w_slot_free = !r_res_valid || res_ready;

  // First asserted request at or after the pointer, searching upward modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = wrap_idx({1'b0, r_rr_ptr} + (IDW+1)'(k));
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // A pair is taken only when a requester is waiting, the slot is open and reset is released.
  assign w_accept = rst && w_found && w_slot_free;

  // One-hot grant toward the selected requester; zero on backpressure, idle or reset.
  always_comb begin
    w_grant = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_accept && (w_win == IDW'(i))) begin
        w_grant[i] = 1'b1;
      end
    end
  end

  // Operand mux selecting the winner's slices of a_bus and b_bus.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_a = a_bus[i*SIZE +: SIZE];
        w_b = b_bus[i*SIZE +: SIZE];
      end
    end
  end

  // Full-width product; (2^SIZE-1)^2 always fits in 2*SIZE bits.
  assign w_prod = PW'(w_a) * PW'(w_b);

  // Priority moves to the requester just after the one that was served.
  assign w_next_ptr = wrap_idx({1'b0, w_win} + (IDW+1)'(1));

  // Result register: load on accept (overriding a same-edge consume), clear valid on consume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else if (w_accept) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_prod;
      r_res_id    <= w_win;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  // Round-robin pointer advances only on an accepted pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= w_next_ptr;
    end
  end

  // Count of accepted pairs since reset, wrapping at 2^CNTW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_cnt <= '0;
    end else if (w_accept) begin
      r_issue_cnt <= r_issue_cnt + CNTW'(1);
    end
  end

  assign req_ready = w_grant;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign issue_cnt = r_issue_cnt;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Scoreboard bench for mult_rr_scheduler (SIZE=8, NREQ=4, CNTW=16).
// Expected products are queued when a pair is granted and checked while held
// and when consumed. The grant, occupancy and count come from a small model.
module tb_mult_rr_scheduler;

  localparam int unsigned SIZE = 8;
  localparam int unsigned NREQ = 4;
  localparam int unsigned CNTW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*SIZE-1:0] a_bus;
  logic [NREQ*SIZE-1:0] b_bus;
  logic              res_valid;
  logic              res_ready;
  logic [2*SIZE-1:0] res_data;
  logic [1:0]        res_id;
  logic [CNTW-1:0]   issue_cnt;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  id;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [1:0]  m_ptr;
  logic        m_valid;
  logic [15:0] m_cnt;

  mult_rr_scheduler #(.SIZE(SIZE), .NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .issue_cnt (issue_cnt)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Apply inputs at the falling edge and let combinational outputs settle.
  task automatic drive(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic rdy);
    req_valid = v;
    a_bus     = a;
    b_bus     = b;
    res_ready = rdy;
    #1;
  endtask

  // Check one cycle against the model, update the scoreboard, advance to the next falling edge.
  task automatic cycle();
    logic [3:0] exp_rdy;
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;
    exp_t       e;
    exp_rdy = '0;
    found   = 1'b0;
    win     = '0;
    if (!m_valid || res_ready) begin
      for (int k = 0; k < 4; k++) begin
        idx = m_ptr + 2'(k);
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end
    if (found) exp_rdy[win] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
    if (m_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        chk("res_data", 32'(res_data), 32'(sb_q[0].data));
        chk("res_id", 32'(res_id), 32'(sb_q[0].id));
        if (res_ready) void'(sb_q.pop_front());
      end
    end
    if (found) begin
      e.data = 16'(a_bus[win*8 +: 8]) * 16'(b_bus[win*8 +: 8]);
      e.id   = win;
      sb_q.push_back(e);
      m_ptr  = win + 2'd1;
      m_cnt  = m_cnt + 16'd1;
    end
    m_valid = found || (m_valid && !res_ready);
    @(negedge clk);
  endtask

  // Assert reset, check cleared outputs immediately, clear the model, release after two cycles.
  task automatic apply_reset();
    rst = 1'b0;
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    sb_q.delete();
    m_ptr   = '0;
    m_valid = 1'b0;
    m_cnt   = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    a_bus     = '0;
    b_bus     = '0;
    res_ready = 1'b0;
    m_ptr     = '0;
    m_valid   = 1'b0;
    m_cnt     = '0;
    @(negedge clk);
    apply_reset();

    // Single requester 2: 0x0C * 0x0B.
    drive(4'b0100, 32'h000C_0000, 32'h000B_0000, 1'b1);
    chk("t1_grant", 32'(req_ready), 32'h4);
    cycle();
    drive(4'b0000, 32'h0, 32'h0, 1'b1);
    chk("t1_data", 32'(res_data), 32'h0084);
    chk("t1_id", 32'(res_id), 32'd2);
    chk("t1_cnt", 32'(issue_cnt), 32'd1);
    cycle();

    // All requesters valid from reset: grants rotate 0,1,2,3,0,...
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      drive(4'hF, $urandom, $urandom, 1'b1);
      chk("t2_grant", 32'(req_ready), 32'(1) << (k % 4));
      if (k > 0) chk("t2_id", 32'(res_id), 32'((k - 1) % 4));
      cycle();
    end
    drive(4'h0, 32'h0, 32'h0, 1'b1);
    cycle();

    // Extreme operands: 0xFF*0xFF on req 1, 0x00*0xFF on req 3.
    apply_reset();
    drive(4'b1010, 32'h0000_FF00, 32'hFF00_FF00, 1'b1);
    chk("t3_grant0", 32'(req_ready), 32'h2);
    cycle();
    drive(4'b1000, 32'h0000_FF00, 32'hFF00_FF00, 1'b1);
    chk("t3_data0", 32'(res_data), 32'hFE01);
    chk("t3_id0", 32'(res_id), 32'd1);
    cycle();
    drive(4'b0000, 32'h0, 32'h0, 1'b1);
    chk("t3_data1", 32'(res_data), 32'h0000);
    chk("t3_id1", 32'(res_id), 32'd3);
    cycle();

    // Backpressure for three cycles with requests pending, then release.
    drive(4'hF, $urandom, $urandom, 1'b1);
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(4'hF, $urandom, $urandom, 1'b0);
      chk("t4_hold_ready", 32'(req_ready), 32'd0);
      cycle();
    end
    drive(4'hF, $urandom, $urandom, 1'b1);
    cycle();
    drive(4'h0, 32'h0, 32'h0, 1'b1);
    cycle();

    // Reset mid-stream while a result is held.
    for (int k = 0; k < 3; k++) begin
      drive(4'hF, $urandom, $urandom, 1'b1);
      cycle();
    end
    apply_reset();
    drive(4'hF, $urandom, $urandom, 1'b1);
    chk("t5_first_grant", 32'(req_ready), 32'h1);
    cycle();
    drive(4'h0, 32'h0, 32'h0, 1'b1);
    cycle();

    // Random traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      drive(4'($urandom_range(0, 15)), $urandom, $urandom, ($urandom_range(0, 3) != 0));
      cycle();
    end
    drive(4'h0, 32'h0, 32'h0, 1'b1);
    cycle();

    // Counter wrap: 65535 accepts reach 0xFFFF, the next one wraps to 0.
    apply_reset();
    for (int k = 0; k < 65535; k++) begin
      drive(4'hF, $urandom, $urandom, 1'b1);
      cycle();
    end
    drive(4'hF, $urandom, $urandom, 1'b1);
    chk("t6_cnt_max", 32'(issue_cnt), 32'hFFFF);
    cycle();
    drive(4'h0, 32'h0, 32'h0, 1'b1);
    chk("t6_cnt_wrap", 32'(issue_cnt), 32'h0000);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
